// File: rtl/burst_pkg.sv
// Shared burst/response codes, FSM state encoding and WRAP length legality
// for the burst write merge pipeline.
package burst_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_SLVERR = 2'd2
    } resp_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // WRAP bursts must be 2, 4, 8 or 16 beats (length field = beats - 1).
    function automatic logic wrap_len_legal(input logic [31:0] len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

endpackage

// File: rtl/burst_write_merge_pipeline_if.sv
// Command, beat, memory-write and response signals of the burst write pipeline.
// slave = pipeline side, master = front end / memory / response consumer side.
interface burst_write_merge_pipeline_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic [ADDR_WIDTH-1:0] u_addr;
    logic [LEN_WIDTH-1:0]  u_length;
    logic [1:0]            u_burst;
    logic                  u_addr_valid;
    logic                  u_addr_ready;
    logic [DATA_WIDTH-1:0] u_data;
    logic                  u_data_last;
    logic                  u_data_valid;
    logic                  u_data_ready;
    logic                  m_wr_en;
    logic [ADDR_WIDTH-1:0] m_wr_addr;
    logic [DATA_WIDTH-1:0] m_wr_data;
    logic [ADDR_WIDTH-1:0] d_resp_addr;
    logic [1:0]            d_resp_code;
    logic                  d_valid;
    logic                  d_ready;

    modport slave (
        input  u_addr, u_length, u_burst, u_addr_valid,
        input  u_data, u_data_last, u_data_valid, d_ready,
        output u_addr_ready, u_data_ready, m_wr_en, m_wr_addr, m_wr_data,
        output d_resp_addr, d_resp_code, d_valid
    );

    modport master (
        output u_addr, u_length, u_burst, u_addr_valid,
        output u_data, u_data_last, u_data_valid, d_ready,
        input  u_addr_ready, u_data_ready, m_wr_en, m_wr_addr, m_wr_data,
        input  d_resp_addr, d_resp_code, d_valid
    );
endinterface

// File: rtl/burst_write_merge_pipeline_resp_fifo.sv
// Synchronous response FIFO with occupancy count; head data reads as zero when empty.
module resp_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/burst_write_merge_pipeline.sv
// Joins one burst command with its data beats into per-beat memory writes and
// queues one OKAY/SLVERR response per burst.
module burst_write_merge_pipeline
    import burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned RESP_FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    burst_write_merge_pipeline_if.slave bus
);
    localparam int unsigned CW     = $clog2(RESP_FIFO_DEPTH) + 1;
    localparam int unsigned RESP_W = ADDR_WIDTH + 2;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, start_q, mask_q, next_addr;
    logic [LEN_WIDTH-1:0]  cnt_q;
    burst_t                mode_q;
    logic                  err_q;

    logic                  addr_ready, data_ready;
    logic                  cmd_fire, beat_fire, beat_err, cmd_err;
    logic                  push;
    logic [RESP_W-1:0]     push_data, head;
    logic [CW-1:0]         fifo_count;

    assign cmd_fire  = bus.u_addr_valid && addr_ready;
    assign beat_fire = bus.u_data_valid && data_ready;
    assign beat_err  = bus.u_data_last != (cnt_q == '0);
    assign cmd_err   = (bus.u_burst == BURST_RSVD) ||
                       ((bus.u_burst == BURST_WRAP) && !wrap_len_legal(32'(bus.u_length)));
    assign push_data = {start_q, ((err_q || beat_err) ? RESP_SLVERR : RESP_OKAY)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Slot in the FIFO is reserved at command accept, so BURST never waits on it.
    always_comb begin
        state_d    = state_q;
        addr_ready = 1'b0;
        data_ready = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                addr_ready = !rst && (fifo_count < CW'(RESP_FIFO_DEPTH));
                if (cmd_fire) state_d = ST_BURST;
            end
            ST_BURST: begin
                data_ready = 1'b1;
                if (beat_fire && (cnt_q == '0)) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        unique case (mode_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (addr_q & ~mask_q) | ((addr_q + ADDR_WIDTH'(1)) & mask_q);
            default:     next_addr = addr_q + ADDR_WIDTH'(1);
        endcase
    end

    // Reserved types and illegal WRAP lengths are captured as INCR for stepping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            start_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= BURST_FIXED;
            err_q   <= 1'b0;
        end else if (cmd_fire) begin
            addr_q  <= bus.u_addr;
            start_q <= bus.u_addr;
            mask_q  <= ADDR_WIDTH'(bus.u_length);
            cnt_q   <= bus.u_length;
            mode_q  <= cmd_err ? BURST_INCR : burst_t'(bus.u_burst);
            err_q   <= cmd_err;
        end else if (beat_fire) begin
            err_q <= err_q || beat_err;
            if (cnt_q != '0) begin
                cnt_q  <= cnt_q - LEN_WIDTH'(1);
                addr_q <= next_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_wr_en   <= 1'b0;
            bus.m_wr_addr <= '0;
            bus.m_wr_data <= '0;
        end else begin
            bus.m_wr_en <= beat_fire;
            if (beat_fire) begin
                bus.m_wr_addr <= addr_q;
                bus.m_wr_data <= bus.u_data;
            end
        end
    end

    resp_fifo #(
        .WIDTH (RESP_W),
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.d_ready),
        .pop_data  (head),
        .count     (fifo_count)
    );

    assign bus.u_addr_ready = addr_ready;
    assign bus.u_data_ready = data_ready;
    assign bus.d_valid      = (fifo_count != '0);
    assign bus.d_resp_addr  = head[RESP_W-1:2];
    assign bus.d_resp_code  = head[1:0];
endmodule
